// File: rtl/cdc_bus_arbiter_if.sv
// Shared CDC channel bundle: requester side (req_in/req_data), destination side (bus_*), status.
// The arbiter takes the master modport; the environment driving requests and ack takes slave.
interface cdc_bus_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8
);
    logic [NUM_REQ-1:0]            req_in;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [DATA_WIDTH-1:0]         bus_data;
    logic                          bus_en;
    logic                          bus_ack;
    logic [NUM_REQ-1:0]            done;
    logic                          err;
    logic                          busy;

    modport master (
        input  req_in, req_data, bus_ack,
        output bus_data, bus_en, done, err, busy
    );

    modport slave (
        output req_in, req_data, bus_ack,
        input  bus_data, bus_en, done, err, busy
    );
endinterface

// File: rtl/cdc_bus_arbiter.sv
// Round-robin owner of one CDC channel: latches a payload, raises bus_en, runs a 4-phase en/ack handshake.
// Grant one edge after a sampled request; SYNC_STAGES+1 edges per ack edge; timeout frees a dead destination.
module cdc_bus_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int DATA_WIDTH     = 8,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic               CLK,
    input  logic               RST,
    cdc_bus_arbiter_if.master  bus
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] TO_LAST = (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {IDLE, REQ, RELEASE} state_e;

    state_e                  state_q, state_d;
    logic [SYNC_STAGES-1:0]  ack_sync_q;
    logic                    ack_s;
    logic [IDX_W-1:0]        last_q, last_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    en_q, en_d;
    logic [NUM_REQ-1:0]      done_q, done_d;
    logic                    err_q, err_d;
    logic [IDX_W-1:0]        win;
    logic                    found;
    int                      cand;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ack_sync_q <= '0;
        end else begin
            ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], bus.bus_ack};
        end
    end

    assign ack_s = ack_sync_q[SYNC_STAGES-1];

    // Search starts one past the last served requester so a held request cannot starve the others.
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = (int'(last_q) + i) % NUM_REQ;
            if (!found && bus.req_in[cand]) begin
                found = 1'b1;
                win   = IDX_W'(cand);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        en_d    = en_q;
        done_d  = '0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                // done_q high marks the cooldown cycle: the served requester gets time to drop its request.
                if (found && (done_q == '0)) begin
                    data_d  = bus.req_data[int'(win)*DATA_WIDTH +: DATA_WIDTH];
                    idx_d   = win;
                    en_d    = 1'b1;
                    cnt_d   = '0;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (ack_s) begin
                    en_d    = 1'b0;
                    state_d = RELEASE;
                end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == TO_LAST)) begin
                    en_d    = 1'b0;
                    err_d   = 1'b1;
                    state_d = RELEASE;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RELEASE: begin
                if (!ack_s) begin
                    done_d  = NUM_REQ'(1) << idx_q;
                    last_d  = idx_q;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
            last_q  <= IDX_W'(NUM_REQ - 1);
            idx_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            en_q    <= 1'b0;
            done_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            en_q    <= en_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign bus.bus_data = data_q;
    assign bus.bus_en   = en_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;
    assign bus.busy     = (state_q != IDLE);

endmodule

// File: tb/tb_cdc_bus_arbiter.sv
`timescale 1ns/1ps
// Scoreboard bench: stimulus pushes expected transfers, a negedge monitor pops and checks them.
module tb_cdc_bus_arbiter;
    localparam int N = 4;
    localparam int W = 8;
    localparam int S = 2;
    localparam int T = 10;

    typedef struct {
        int           idx;
        logic [W-1:0] data;
        int           err;
        int           en_cycles;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic resp_auto = 1'b0;
    logic ack_auto = 1'b0;
    logic ack_man = 1'b0;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass = 0;
    int   grants_seen = 0;
    int   dones_seen = 0;
    int   model_last = N - 1;

    always #5 clk = ~clk;

    cdc_bus_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(W)) bif ();

    assign bif.bus_ack = resp_auto ? ack_auto : ack_man;

    cdc_bus_arbiter #(
        .NUM_REQ(N), .DATA_WIDTH(W), .SYNC_STAGES(S), .TIMEOUT_CYCLES(T)
    ) dut (
        .CLK(clk),
        .RST(rst_n),
        .bus(bif)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic fail_evt(input string name);
        n_checks++;
        $display("FAIL %s: event observed where none was expected", name);
    endtask

    function automatic int rr_next(input int last, input logic [N-1:0] mask);
        for (int i = 1; i <= N; i++) begin
            if (mask[(last + i) % N]) return (last + i) % N;
        end
        return -1;
    endfunction

    task automatic push_exp(input int idx, input logic [W-1:0] data, input int err, input int en_cycles);
        exp_t e;
        e.idx = idx;
        e.data = data;
        e.err = err;
        e.en_cycles = en_cycles;
        exp_q.push_back(e);
    endtask

    task automatic wait_grants(input int target);
        int n = 0;
        while (grants_seen < target && n < 400) begin
            @(negedge clk); #1;
            n++;
        end
        chk("wait_grant", 32'(grants_seen >= target), 32'd1);
    endtask

    task automatic wait_dones(input int target);
        int n = 0;
        while (dones_seen < target && n < 600) begin
            @(negedge clk); #1;
            n++;
        end
        chk("wait_done", 32'(dones_seen >= target), 32'd1);
    endtask

    // Monitor: pops one expectation per bus_en rise and closes it on the done pulse.
    initial begin
        logic prev_en, prev_err, inflight, stable, cool;
        int   en_cyc, err_cnt;
        exp_t cur;
        prev_en = 0; prev_err = 0; inflight = 0; stable = 1; cool = 0;
        en_cyc = 0; err_cnt = 0;
        cur.idx = 0; cur.data = '0; cur.err = 0; cur.en_cycles = -1;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_en = 0; prev_err = 0; inflight = 0; cool = 0;
                continue;
            end
            if (cool) begin
                chk("cooldown_no_grant", 32'(bif.bus_en), 32'd0);
                cool = 0;
            end
            if (bif.bus_en && !prev_en) begin
                grants_seen++;
                if (exp_q.size() == 0) begin
                    fail_evt("unexpected_grant");
                end else begin
                    cur = exp_q.pop_front();
                    inflight = 1; stable = 1; en_cyc = 0; err_cnt = 0;
                    chk("grant_data", 32'(bif.bus_data), 32'(cur.data));
                    chk("grant_busy", 32'(bif.busy), 32'd1);
                end
            end
            if (inflight) begin
                if (bif.bus_data !== cur.data) stable = 0;
                if (bif.bus_en) en_cyc++;
            end
            if (bif.err) begin
                if (!inflight) fail_evt("unexpected_err");
                err_cnt++;
                chk("err_after_en_fall", 32'({prev_en, bif.bus_en}), 32'd2);
            end
            if (bif.done != '0) begin
                if (!inflight) begin
                    fail_evt("unexpected_done");
                end else begin
                    chk("done_onehot", 32'(bif.done), 32'd1 << cur.idx);
                    chk("err_count", 32'(err_cnt), 32'(cur.err));
                    if (cur.err != 0) chk("done_after_err", 32'(prev_err), 32'd1);
                    if (cur.en_cycles >= 0) chk("en_high_cycles", 32'(en_cyc), 32'(cur.en_cycles));
                    chk("data_stable", 32'(stable), 32'd1);
                    chk("done_busy_low", 32'(bif.busy), 32'd0);
                    inflight = 0;
                end
                dones_seen++;
                cool = 1;
            end
            prev_en = bif.bus_en;
            prev_err = bif.err;
        end
    end

    // Destination responder with random, clock-unaligned ack edges.
    initial begin
        forever begin
            @(negedge clk);
            if (resp_auto && bif.bus_en && !ack_auto) begin
                repeat ($urandom_range(0, 3)) @(posedge clk);
                #($urandom_range(1, 9));
                ack_auto = 1'b1;
                for (int n = 0; n < 100 && bif.bus_en; n++) @(negedge clk);
                repeat ($urandom_range(0, 3)) @(posedge clk);
                #($urandom_range(1, 9));
                ack_auto = 1'b0;
            end
        end
    end

    task automatic run_batch(input logic [N-1:0] mask, input bit use_victim);
        int order[$];
        logic [N-1:0] m;
        logic [W-1:0] d [N];
        int l, victim, g0, d0;
        m = mask;
        l = model_last;
        while (m != '0) begin
            l = rr_next(l, m);
            order.push_back(l);
            m[l] = 1'b0;
        end
        victim = -1;
        if (use_victim && order.size() >= 2) begin
            int vpos;
            vpos = 1 + int'($urandom_range(0, order.size() - 2));
            victim = order[vpos];
            order.delete(vpos);
        end
        for (int i = 0; i < N; i++) begin
            d[i] = W'($urandom);
            if (mask[i]) bif.req_data[i*W +: W] = d[i];
        end
        foreach (order[k]) push_exp(order[k], d[order[k]], 0, -1);
        g0 = grants_seen;
        d0 = dones_seen;
        @(negedge clk); #1;
        bif.req_in = bif.req_in | mask;
        foreach (order[k]) begin
            wait_grants(g0 + k + 1);
            bif.req_data[order[k]*W +: W] = W'($urandom);
            if (k == 0 && victim >= 0) bif.req_in[victim] = 1'b0;
            if ($urandom_range(0, 1) == 1) bif.req_in[order[k]] = 1'b0;
            wait_dones(d0 + k + 1);
            bif.req_in[order[k]] = 1'b0;
        end
        model_last = order[order.size() - 1];
    endtask

    initial begin
        int g0, d0, n, l;
        logic [W-1:0] dv;
        bif.req_in = '0;
        bif.req_data = '0;
        #12;
        chk("rst_bus_en", 32'(bif.bus_en), 32'd0);
        chk("rst_bus_data", 32'(bif.bus_data), 32'd0);
        chk("rst_done", 32'(bif.done), 32'd0);
        chk("rst_err", 32'(bif.err), 32'd0);
        chk("rst_busy", 32'(bif.busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Fairness: all four held for six transfers.
        resp_auto = 1'b1;
        for (int i = 0; i < N; i++) bif.req_data[i*W +: W] = W'(8'h10 + i);
        l = model_last;
        for (int k = 0; k < 6; k++) begin
            l = rr_next(l, 4'hF);
            push_exp(l, W'(8'h10 + l), 0, -1);
        end
        model_last = l;
        d0 = dones_seen;
        @(negedge clk); #1;
        bif.req_in = 4'hF;
        wait_dones(d0 + 6);
        bif.req_in = '0;
        repeat (4) @(negedge clk);
        resp_auto = 1'b0;

        // Single transfer with measured ack/release latencies.
        bif.req_data[1*W +: W] = 8'hA5;
        push_exp(1, 8'hA5, 0, 3 + S + 1);
        g0 = grants_seen; d0 = dones_seen;
        @(negedge clk); #1;
        bif.req_in = 4'b0010;
        wait_grants(g0 + 1);
        repeat (3) @(negedge clk); #1;
        ack_man = 1'b1;
        n = 0;
        do begin @(negedge clk); #1; n++; end while (bif.bus_en && n < 20);
        chk("ack_to_en_fall", 32'(n), 32'(S + 1));
        repeat (2) @(negedge clk); #1;
        ack_man = 1'b0;
        n = 0;
        do begin @(negedge clk); #1; n++; end while (bif.done == '0 && n < 20);
        chk("ack_drop_to_done", 32'(n), 32'(S + 1));
        bif.req_in = '0;
        @(negedge clk); #1;
        chk("single_busy_after", 32'(bif.busy), 32'd0);
        model_last = 1;

        // Random batches against the round-robin model.
        resp_auto = 1'b1;
        repeat (8) run_batch(N'($urandom_range(1, (1 << N) - 1)), 1'($urandom_range(0, 1)));
        repeat (6) @(negedge clk);
        resp_auto = 1'b0;

        // Dead destination: timeout.
        dv = W'($urandom);
        bif.req_data[2*W +: W] = dv;
        push_exp(2, dv, 1, T);
        d0 = dones_seen;
        @(negedge clk); #1;
        bif.req_in = 4'b0100;
        wait_dones(d0 + 1);
        bif.req_in = '0;
        model_last = 2;
        repeat (3) @(negedge clk);

        // Ack synchronized on exactly the timeout cycle: ack wins.
        dv = W'($urandom);
        bif.req_data[1*W +: W] = dv;
        push_exp(1, dv, 0, T);
        g0 = grants_seen; d0 = dones_seen;
        @(negedge clk); #1;
        bif.req_in = 4'b0010;
        wait_grants(g0 + 1);
        repeat (T - S - 1) @(negedge clk); #1;
        ack_man = 1'b1;
        for (int k = 0; k < 40 && bif.bus_en; k++) begin @(negedge clk); #1; end
        ack_man = 1'b0;
        wait_dones(d0 + 1);
        bif.req_in = '0;
        model_last = 1;
        repeat (3) @(negedge clk);

        // Spurious ack while idle, then a grant that must not be blocked.
        ack_man = 1'b1;
        repeat (8) @(negedge clk); #1;
        chk("spurious_no_en", 32'(bif.bus_en), 32'd0);
        chk("spurious_not_busy", 32'(bif.busy), 32'd0);
        dv = W'($urandom);
        bif.req_data[0 +: W] = dv;
        push_exp(0, dv, 0, -1);
        d0 = dones_seen;
        ack_man = 1'b0;
        bif.req_in = 4'b0001;
        wait_dones(d0 + 1);
        bif.req_in = '0;
        model_last = 0;
        repeat (3) @(negedge clk);

        // Reset in the middle of REQ.
        dv = W'($urandom_range(1, 255));
        bif.req_data[3*W +: W] = dv;
        push_exp(rr_next(model_last, 4'b1000), dv, 0, -1);
        g0 = grants_seen;
        @(negedge clk); #1;
        bif.req_in = 4'b1000;
        wait_grants(g0 + 1);
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_bus_en", 32'(bif.bus_en), 32'd0);
        chk("midrst_busy", 32'(bif.busy), 32'd0);
        chk("midrst_bus_data", 32'(bif.bus_data), 32'd0);
        chk("midrst_done_err", 32'({bif.done, bif.err}), 32'd0);
        bif.req_in = '0;
        model_last = N - 1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        resp_auto = 1'b1;
        run_batch(4'b1001, 1'b0);
        run_batch(4'b1000, 1'b0);
        repeat (6) @(negedge clk);

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached, %0d/%0d checks passed so far", n_pass, n_checks);
        $fatal(1);
    end
endmodule

// File: doc/cdc_bus_arbiter.md
# cdc_bus_arbiter

Source-domain controller that shares one multi-bit clock-domain-crossing channel among `NUM_REQ` requesters. It grants requesters round-robin, drives the bus data and a level enable into the destination domain, and runs a 4-phase enable/ack handshake. The ack returns asynchronously and is synchronized internally. A timeout recovers the channel from a dead destination. The block sits in the data-sync subsystem ahead of the destination-side enable synchronizer and pulse generator.

## Interface
- `NUM_REQ`, 4: number of requesters (≥2).
- `DATA_WIDTH`, 8: bus payload width.
- `SYNC_STAGES`, 2: flops in the ack synchronizer (≥2).
- `TIMEOUT_CYCLES`, 255: maximum cycles `bus_en` stays high waiting for ack. 0 disables the timeout.

Ports:
- `CLK`  input  1  source-domain clock; all logic on rising edge.
- `RST`  input  1  asynchronous, active-low reset.
- `req_in`  input  NUM_REQ  level request per requester; held until that requester's `done` pulse.
- `req_data`  input  NUM_REQ*DATA_WIDTH  flattened payloads; slice i = bits [i*DATA_WIDTH +: DATA_WIDTH].
- `bus_data`  output  DATA_WIDTH  registered payload to the destination domain.
- `bus_en`  output  1  registered level enable to the destination domain.
- `bus_ack`  input  1  destination acknowledge; asynchronous to `CLK`.
- `done`  output  NUM_REQ  one-hot, one-cycle pulse: transfer for requester i finished.
- `err`  output  1  one-cycle pulse on timeout.
- `busy`  output  1  high whenever state ≠ IDLE.

## Operation
- `ack_s` is `bus_ack` after `SYNC_STAGES` flops. All flops reset to 0.
- Round-robin pointer `last` holds the index of the last requester served. Reset value is NUM_REQ-1, so requester 0 has first priority.
- The search order is last+1, last+2, … modulo NUM_REQ.

State machine:
- **IDLE**
  - If any `req_in` bit is set and `done` was not pulsed in this cycle, pick the winner `w` by round-robin.
  - On that edge: latch `bus_data` ← slice w, `idx` ← w, `bus_en` ← 1, clear the timeout counter, go to REQ.
- **REQ**
  - If `ack_s`=1: `bus_en` ← 0, go to RELEASE.
  - Else, if TIMEOUT_CYCLES≠0 and the counter = TIMEOUT_CYCLES-1: `bus_en` ← 0, pulse `err`, go to RELEASE.
  - Else increment the counter.
  - If ack and timeout fall on the same cycle, ack wins and there is no `err`.
- **RELEASE**
  - When `ack_s`=0: pulse `done[idx]`, `last` ← idx, go to IDLE.
  - No timeout applies in this state.

Data and width rules:
- `bus_data` is stable from the `bus_en` rise until RELEASE exits. It keeps its last value while in IDLE.
- Changes to `req_data` after the grant are ignored.
- Timeout counter width is $clog2(TIMEOUT_CYCLES+1), saturating, never wrapping.

Boundary conditions:
- `ack_s` high while in IDLE (stale or spurious) is ignored; no grant is blocked by it.
- A requester that drops `req_in` before it is granted is simply not selected. Dropping after the grant does not abort the transfer.
- All requests asserted at once are served in order 0,1,…,NUM_REQ-1, then wrap.
- **Cooldown:** the IDLE cycle in which `done` is high never grants, so the just-served requester can deassert.
- **Reset mid-transfer:** `bus_en`, `bus_data`, `done`, `err`, `busy`, counter and sync flops go to 0 immediately; `last` goes to NUM_REQ-1; state goes to IDLE.

## Timing
- Reset values: `bus_en`=0, `bus_data`=0, `done`=0, `err`=0, `busy`=0.
- Grant latency: `req_in` sampled high in IDLE at edge k gives `bus_en`=1 and valid `bus_data` after edge k.
- Ack path: `bus_ack` rises → `ack_s` high after SYNC_STAGES edges → `bus_en` falls on the following edge.
- Release path: `bus_ack` falls → `ack_s` low after SYNC_STAGES edges → `done` high for the next cycle.
- Minimum spacing between grants is 1 cooldown cycle.
- Best-case cycle count per transfer with an immediate ack is 2·(SYNC_STAGES+1)+2.
- Timeout: `bus_en` is high for exactly TIMEOUT_CYCLES cycles. `err` is high on the cycle after the `bus_en` fall edge, concurrent with entry to RELEASE.

## Test plan
- **Single transfer:** NUM_REQ=4, SYNC_STAGES=2; `req_in`=0010, slice1=0xA5; ack 3 cycles after `bus_en` rise, drop 3 cycles after `bus_en` fall.
  - Expect `bus_data`=0xA5 throughout, one `done`=0010 pulse, `err`=0, `busy` low after.
- **Fairness:** `req_in`=1111 held continuously (each requester re-asserts after its done).
  - Grant order 0,1,2,3,0,1; ≥1 IDLE cycle between transfers; no requester granted twice in a row.
- **Timeout:** TIMEOUT_CYCLES=10, `bus_ack` tied 0.
  - `bus_en` high exactly 10 cycles, one `err` pulse, then `done` one cycle later (ack_s already 0).
- **Ack vs. timeout tie:** `ack_s` reaches 1 on the timeout cycle.
  - No `err`; normal RELEASE.
- **Reset mid-REQ:** deassert `RST` mid-cycle while `bus_en`=1.
  - `bus_en`=0 and `busy`=0 asynchronously; after release with `req_in`=1000, requester 3 is granted (pointer reset).
- **Spurious ack in IDLE:** `bus_ack` high with `req_in`=0.
  - No `bus_en`, no `done`. Then assert `req_in`=0001 and lower ack: the transfer completes normally.
